// File: rtl/can_multi_transceiver_if.sv
//======================================================================
// Module      : can_multi_transceiver_if
// Description : Per-node TXD/STBY/RXD bundle and shared bus status
//               between CAN controllers and the multi-node transceiver.
// Revision    : 1.0 - initial release
//======================================================================
`default_nettype none

interface can_multi_transceiver_if #(
   parameter int N_NODES = 2
);
   logic [N_NODES-1:0] tx_i;
   logic [N_NODES-1:0] rs_i;
   logic [N_NODES-1:0] rx_o;
   logic               bus_o;
   logic [N_NODES-1:0] timeout_o;
   logic [N_NODES-1:0] wake_o;

   modport master (
      output tx_i, rs_i,
      input  rx_o, bus_o, timeout_o, wake_o
   );

   modport slave (
      input  tx_i, rs_i,
      output rx_o, bus_o, timeout_o, wake_o
   );
endinterface

`default_nettype wire

// File: rtl/can_multi_transceiver.sv
//======================================================================
// Module      : can_multi_transceiver
// Description : Cycle-based wired-AND CAN physical layer for N_NODES
//               controllers with TXD delay, standby and dominant timeout.
//               Optional wake-up detection: define CAN_PHY_WAKE_EN.
// Revision    : 1.0 - initial release
//======================================================================
`default_nettype none

module can_multi_transceiver #(
   parameter int N_NODES     = 2,
   parameter int DELAY_CYC   = 2,
   parameter int TIMEOUT_CYC = 1024,
   parameter int WAKE_CYC    = 8
) (
   input  wire logic              clk_i,
   input  wire logic              rst_i,
   can_multi_transceiver_if.slave bus_if
);

   localparam int                c_TO_W   = $clog2(TIMEOUT_CYC + 1);
   localparam logic [c_TO_W-1:0] c_TO_MAX = c_TO_W'(TIMEOUT_CYC);
   localparam logic [c_TO_W-1:0] c_TO_PRE = c_TO_W'(TIMEOUT_CYC - 1);

`ifdef CAN_PHY_WAKE_EN
   localparam int                c_WK_W   = $clog2(WAKE_CYC + 1);
   localparam logic [c_WK_W-1:0] c_WK_MAX = c_WK_W'(WAKE_CYC);
   localparam logic [c_WK_W-1:0] c_WK_PRE = c_WK_W'(WAKE_CYC - 1);
`endif

   if (N_NODES < 2) begin : g_chk_nodes
      $error("N_NODES must be at least 2");
   end
   if (DELAY_CYC < 1) begin : g_chk_delay
      $error("DELAY_CYC must be at least 1");
   end
   if (TIMEOUT_CYC < 2) begin : g_chk_timeout
      $error("TIMEOUT_CYC must be at least 2");
   end
   if (WAKE_CYC < 1) begin : g_chk_wake
      $error("WAKE_CYC must be at least 1");
   end

   logic [N_NODES-1:0] w_drv;
   logic               w_bus;

   // Bus is a pure function of registered state and rs_i, never of tx_i.
   assign w_bus        = ~|w_drv;
   assign bus_if.bus_o = w_bus;

   for (genvar n = 0; n < N_NODES; n++) begin : g_node
      logic [DELAY_CYC-1:0] r_dly;
      logic [c_TO_W-1:0]    r_to_cnt;
      logic                 r_timeout;
      logic                 r_rx;

      if (DELAY_CYC == 1) begin : g_dly_single
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               r_dly <= '1;
            end else begin
               r_dly <= bus_if.tx_i[n];
            end
         end
      end else begin : g_dly_chain
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               r_dly <= '1;
            end else begin
               r_dly <= {r_dly[DELAY_CYC-2:0], bus_if.tx_i[n]};
            end
         end
      end

      assign w_drv[n] = ~r_dly[DELAY_CYC-1] & ~bus_if.rs_i[n] & ~r_timeout;

      // Timeout counts raw TXD, independent of standby, and only a
      // recessive TXD sample releases it.
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
         end else if (bus_if.tx_i[n]) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
         end else if (r_to_cnt != c_TO_MAX) begin
            r_to_cnt <= r_to_cnt + 1'b1;
            if (r_to_cnt == c_TO_PRE) begin
               r_timeout <= 1'b1;
            end
         end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            r_rx <= 1'b1;
         end else begin
            r_rx <= bus_if.rs_i[n] ? 1'b1 : w_bus;
         end
      end

      assign bus_if.rx_o[n]      = r_rx;
      assign bus_if.timeout_o[n] = r_timeout;

`ifdef CAN_PHY_WAKE_EN
      logic [c_WK_W-1:0] r_wk_cnt;
      logic              r_wake;

      // Wake flag is sticky while in standby; leaving standby clears it.
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            r_wk_cnt <= '0;
            r_wake   <= 1'b0;
         end else if (!bus_if.rs_i[n]) begin
            r_wk_cnt <= '0;
            r_wake   <= 1'b0;
         end else if (w_bus) begin
            r_wk_cnt <= '0;
         end else if (r_wk_cnt != c_WK_MAX) begin
            r_wk_cnt <= r_wk_cnt + 1'b1;
            if (r_wk_cnt == c_WK_PRE) begin
               r_wake <= 1'b1;
            end
         end
      end

      assign bus_if.wake_o[n] = r_wake;
`else
      assign bus_if.wake_o[n] = 1'b0;
`endif
   end

endmodule

`default_nettype wire
